// File: rtl/checkbits_pkg.sv
// Shared types and constants for the checkbits progress-word monitor.
package checkbits_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_START,
        ST_RUN,
        ST_WAIT_END,
        ST_DONE
    } state_t;

    localparam logic [2:0] FC_NONE      = 3'd0;
    localparam logic [2:0] FC_TMO_START = 3'd1;
    localparam logic [2:0] FC_TMO_SEQ   = 3'd2;
    localparam logic [2:0] FC_TMO_END   = 3'd3;
    localparam logic [2:0] FC_EARLY_END = 3'd4;

    localparam logic [15:0] DEF_START_MARK = 16'hAB40;
    localparam logic [15:0] DEF_END_MARK   = 16'hAB51;

endpackage

// File: rtl/checkbits_if.sv
// Bundle of observed word, table-load port, arm strobe and result outputs.
interface checkbits_if #(
    parameter int IDX_W = 2,
    parameter int LAT_W = 32
);
    logic [15:0]      checkbits;
    logic             exp_we;
    logic [IDX_W-1:0] exp_idx;
    logic [15:0]      exp_data;
    logic             arm;
    logic             busy;
    logic             done;
    logic             pass;
    logic [2:0]       fail_code;
    logic [IDX_W:0]   match_cnt;
    logic [LAT_W-1:0] latency;
    logic [15:0]      last_value;

    modport master (
        output checkbits, exp_we, exp_idx, exp_data, arm,
        input  busy, done, pass, fail_code, match_cnt, latency, last_value
    );

    modport slave (
        input  checkbits, exp_we, exp_idx, exp_data, arm,
        output busy, done, pass, fail_code, match_cnt, latency, last_value
    );
endinterface

// File: rtl/checkbits_sampler.sv
// Registers the progress word once and flags cycles where the sample changed.
module checkbits_sampler (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [15:0] pin,
    output logic [15:0] samp,
    output logic        change
);
    logic [15:0] prev;

    // Sample the pin and keep the previous sample for change detection.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            samp <= '0;
            prev <= '0;
        end else begin
            samp <= pin;
            prev <= samp;
        end
    end

    // An X/Z sample makes this unknown, which never qualifies a match.
    assign change = (samp != prev);
endmodule

// File: rtl/checkbits_monitor.sv
// Watches the firmware progress word: start marker, ordered expected values,
// end marker; reports pass/fail code and start-to-end latency.
module checkbits_monitor
    import checkbits_pkg::*;
#(
    parameter logic [15:0] START_MARK  = DEF_START_MARK,
    parameter logic [15:0] END_MARK    = DEF_END_MARK,
    parameter int          NUM_EXP     = 4,
    parameter int          IDX_W       = 2,
    parameter int          TIMEOUT_CYC = 3000000,
    parameter int          LAT_W       = 32
) (
    input logic        wb_clk_i,
    input logic        wb_rst_i,
    checkbits_if.slave bus
);
    state_t           state_q, state_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [2:0]       fc_q, fc_d;
    logic [IDX_W:0]   match_q, match_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [LAT_W-1:0] tmo_q, tmo_d;
    logic [15:0]      exp_tab [NUM_EXP];
    logic [15:0]      samp;
    logic             change;
    logic             idle_like;
    logic             tmo_hit;

    function automatic logic [LAT_W-1:0] sat_inc(input logic [LAT_W-1:0] v);
        return (v == '1) ? v : v + LAT_W'(1);
    endfunction

    checkbits_sampler u_sampler (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .pin      (bus.checkbits),
        .samp     (samp),
        .change   (change)
    );

    assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE);
    // The counter is compared before increment so DONE lands exactly TIMEOUT_CYC edges after arm.
    assign tmo_hit   = (tmo_q >= LAT_W'(TIMEOUT_CYC - 1));

    // Expected-value table: writable only when no run is in progress.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < NUM_EXP; i++) exp_tab[i] <= '0;
        end else if (bus.exp_we && idle_like) begin
            exp_tab[bus.exp_idx] <= bus.exp_data;
        end
    end

    // State and result registers.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fc_q    <= FC_NONE;
            match_q <= '0;
            idx_q   <= '0;
            lat_q   <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            fc_q    <= fc_d;
            match_q <= match_d;
            idx_q   <= idx_d;
            lat_q   <= lat_d;
            tmo_q   <= tmo_d;
        end
    end

    // Next-state and counter logic; markers and matches take priority over timeout.
    always_comb begin
        state_d = state_q;
        done_d  = done_q;
        pass_d  = pass_q;
        fc_d    = fc_q;
        match_d = match_q;
        idx_d   = idx_q;
        lat_d   = lat_q;
        tmo_d   = tmo_q;
        if (!idle_like) tmo_d = tmo_q + LAT_W'(1);
        if ((state_q == ST_RUN) || (state_q == ST_WAIT_END)) lat_d = sat_inc(lat_q);
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.arm) begin
                    state_d = ST_WAIT_START;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    fc_d    = FC_NONE;
                    match_d = '0;
                    idx_d   = '0;
                    lat_d   = '0;
                    tmo_d   = '0;
                end
            end
            ST_WAIT_START: begin
                if (samp == START_MARK) begin
                    state_d = ST_RUN;
                    lat_d   = '0;
                end else if (tmo_hit) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    fc_d    = FC_TMO_START;
                end
            end
            ST_RUN: begin
                if (change && (samp == END_MARK)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    pass_d  = 1'b0;
                    fc_d    = FC_EARLY_END;
                end else if (change && (samp == exp_tab[idx_q])) begin
                    match_d = match_q + (IDX_W+1)'(1);
                    idx_d   = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(NUM_EXP - 1)) state_d = ST_WAIT_END;
                end else if (tmo_hit) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    fc_d    = FC_TMO_SEQ;
                end
            end
            ST_WAIT_END: begin
                if (samp == END_MARK) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    pass_d  = 1'b1;
                end else if (tmo_hit) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    fc_d    = FC_TMO_END;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.busy       = !idle_like;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.fail_code  = fc_q;
    assign bus.match_cnt  = match_q;
    assign bus.latency    = lat_q;
    assign bus.last_value = samp;
endmodule

// File: doc/checkbits_monitor.md
Name: checkbits_monitor

Overview:
- Synthesizable checker consuming the 16-bit firmware progress word on mprj_io[31:16] (checkbits).
- Detects start marker, matches an ordered sequence of expected values, detects end marker, reports pass/fail and cycle latency.
- Replaces ad hoc wait-based checking in lab benches.
- Also drops into the user area as a self-test monitor.

Parameters:
START_MARK, 16'hAB40, value that starts a test run
END_MARK, 16'hAB51, value that ends a test run
NUM_EXP, 4, depth of expected-value table (1..16)
IDX_W, 2, index width, equal to clog2(NUM_EXP) with minimum 1
TIMEOUT_CYC, 3000000, cycles after arm before timeout
LAT_W, 32, width of the latency and timeout counters

Ports:
wb_clk_i  in  1  sole clock
wb_rst_i  in  1  synchronous active-high reset
checkbits  in  16  observed progress word
exp_we  in  1  expected-table write strobe
exp_idx  in  IDX_W  table write index
exp_data  in  16  table write data
arm  in  1  single-cycle start pulse
busy  out  1  run in progress
done  out  1  result valid, held high until re-arm or reset
pass  out  1  run passed; meaningful only while done=1
fail_code  out  3  0 none, 1 timeout waiting start, 2 timeout in sequence, 3 timeout waiting end, 4 early end marker
match_cnt  out  IDX_W+1  expected entries matched so far
latency  out  LAT_W  cycles from start to end
last_value  out  16  most recent sampled checkbits

Behaviour:
- Reset: all outputs 0, FSM IDLE, table cleared to 0, all counters 0.
- Sampling: checkbits is registered once (samp). All compares use samp, so detection lags the pin by 1 cycle.
- Change event: samp != previous samp.
- X/Z on checkbits compares unequal and never matches.
- FSM states: IDLE, WAIT_START, RUN, WAIT_END, DONE.
- IDLE/DONE + arm: go to WAIT_START. Clear done, pass, fail_code, match_cnt, latency, idx, and the timeout counter. busy=1.
- WAIT_START + samp==START_MARK: go to RUN; latency=0.
- RUN:
  - latency increments every cycle, saturating at all-ones.
  - A change event with samp==exp[idx] increments match_cnt and idx.
  - Matching entry NUM_EXP-1 moves to WAIT_END.
  - Other values are ignored; matching is an ordered subsequence.
  - A change event with samp==END_MARK goes to DONE with fail_code=4, pass=0.
- WAIT_END:
  - latency keeps incrementing.
  - samp==END_MARK goes to DONE with pass=1. latency then freezes and includes the end-detect cycle.
- Timeout counter:
  - Runs from arm in WAIT_START, RUN and WAIT_END.
  - Reaching TIMEOUT_CYC goes to DONE with fail_code 1, 2 or 3 according to the state.
  - If timeout and a marker occur in the same cycle, the marker wins.
- DONE: busy=0, done=1; outputs hold.
- Start marker: after start, a reappearance of START_MARK is ignored.
- Repeated table values: equal consecutive entries need separate change events. A stable value matches once.
- Table writes: exp_we is honoured only in IDLE/DONE and ignored while busy. A write and arm in the same cycle: the write lands, then arm proceeds.
- arm while busy is ignored.
- wb_rst_i mid-run returns to the reset state on the next edge and clears the table.

Decomposition:
- Package checkbits_pkg:
  - state enum (5 states)
  - fail-code localparams FC_NONE..FC_EARLY_END
  - default marker constants
- Sub-module checkbits_sampler:
  - input register
  - previous-sample register
  - change-event output
- FSM, counters and table live in the top module.

Test Plan:
1. Table {62,68,74,80}; arm; drive 0xAB40, then 62/68/74/80 spaced 100 cycles; 0xAB51 500 cycles after 0xAB40 -> done=1, pass=1, match_cnt=4, latency=500, fail_code=0.
2. Drive 62,63,65,68,70,74,79,80 then 0xAB51 -> pass=1, match_cnt=4; intermediate values ignored.
3. Drive 62,68 then 0xAB51 -> done=1, pass=0, fail_code=4, match_cnt=2, last_value=16'hAB51.
4. TIMEOUT_CYC=1000; arm; never drive 0xAB40 -> done=1 at 1000 cycles after arm, fail_code=1. Repeat stalling after 2 matches -> fail_code=2.
5. Assert wb_rst_i mid-RUN after 2 matches -> next cycle all outputs 0, table reads 0. Reload the table, re-arm, and rerun test 1 -> pass.
6. Table {68,68,74,80}:
   - Hold 68 for 50 cycles -> match_cnt=1.
   - Drive 69 then 68 -> match_cnt=2.
   - Continue 74, 80, 0xAB51 -> pass=1.
